// File: rtl/hart_timeslice_scheduler.sv
// Time-slice arbiter for the shared MMU/interconnect path of a multi-hart cluster.
// Bounded quantum, interrupt-aware preemption and a drain/switch handshake.
module hart_timeslice_scheduler #(
  parameter int unsigned N_HARTS = 2,
  parameter int unsigned QUANTUM = 1024,
  parameter int unsigned QW      = 16,
  parameter int unsigned SELW    = 4
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic [N_HARTS-1:0]  w_req,
  input  logic [N_HARTS-1:0]  w_urgent,
  input  logic                w_safe,
  input  logic                w_hold,
  output logic [SELW-1:0]     w_sel,
  output logic [N_HARTS-1:0]  w_grant,
  output logic                w_switching,
  output logic [QW-1:0]       w_quantum_left
);

  typedef enum logic [1:0] {StRun, StDrain, StSwitch} state_e;

  state_e               state_q, state_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic [SELW-1:0]      next_sel_q, next_sel_d;
  logic [N_HARTS-1:0]   grant_q, grant_d;
  logic [QW-1:0]        cnt_q, cnt_d;
  logic                 switching_q, switching_d;

  logic                 own_req, own_urg;
  logic                 found_req, found_urg;
  logic [SELW-1:0]      req_sel, urg_sel;
  logic                 cand_valid;
  logic [SELW-1:0]      cand_sel;

  // Round-robin scan from the hart after the owner; urgent requesters take precedence.
  always_comb begin
    own_req   = 1'b0;
    own_urg   = 1'b0;
    found_req = 1'b0;
    found_urg = 1'b0;
    req_sel   = '0;
    urg_sel   = '0;
    for (int unsigned h = 0; h < N_HARTS; h++) begin
      if (32'(sel_q) == h) begin
        own_req = w_req[h];
        own_urg = w_urgent[h];
      end
    end
    for (int unsigned i = 1; i < N_HARTS; i++) begin
      for (int unsigned h = 0; h < N_HARTS; h++) begin
        if (h == (32'(sel_q) + i) % N_HARTS) begin
          if (w_req[h] && !found_req) begin
            found_req = 1'b1;
            req_sel   = SELW'(h);
          end
          if (w_req[h] && w_urgent[h] && !found_urg) begin
            found_urg = 1'b1;
            urg_sel   = SELW'(h);
          end
        end
      end
    end
    cand_valid = found_req;
    cand_sel   = found_urg ? urg_sel : req_sel;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    next_sel_d = next_sel_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StRun: begin
        cnt_d = (cnt_q != '0) ? cnt_q - QW'(1) : cnt_q;
        if (cand_valid && ((cnt_q == '0) || !own_req || (found_urg && !own_urg))) begin
          state_d = StDrain;
        end else if (cnt_q == '0) begin
          cnt_d = QW'(QUANTUM);
        end
      end
      StDrain: begin
        if (!cand_valid) begin
          state_d = StRun;
          cnt_d   = QW'(QUANTUM);
        end else if (w_safe && !w_hold) begin
          state_d    = StSwitch;
          next_sel_d = cand_sel;
          grant_d    = '0;
        end
      end
      StSwitch: begin
        state_d = StRun;
        sel_d   = next_sel_q;
        cnt_d   = QW'(QUANTUM);
        for (int unsigned h = 0; h < N_HARTS; h++) begin
          grant_d[h] = (next_sel_q == SELW'(h));
        end
      end
      default: state_d = StRun;
    endcase
    switching_d = (state_d != StRun);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= StRun;
      sel_q       <= '0;
      next_sel_q  <= '0;
      grant_q     <= N_HARTS'(1);
      cnt_q       <= QW'(QUANTUM);
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      next_sel_q  <= next_sel_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      switching_q <= switching_d;
    end
  end

  assign w_sel          = sel_q;
  assign w_grant        = grant_q;
  assign w_switching    = switching_q;
  assign w_quantum_left = cnt_q;

  a_grant_onehot : assert property (@(posedge CLK) disable iff (!RST_X)
    $onehot0(grant_q) && ((grant_q == '0) == (state_q == StSwitch)));
  a_sel_range : assert property (@(posedge CLK) disable iff (!RST_X)
    32'(sel_q) < N_HARTS);

endmodule

// File: tb/tb_hart_timeslice_scheduler.sv
// Bench for hart_timeslice_scheduler: three instances (1, 2 and 4 harts) against a
// cycle-level reference model, plus directed scenarios.
module tb_hart_timeslice_scheduler;

  localparam int Q = 8;

  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] req_v [3];
  logic [15:0] urg_v [3];
  logic        safe_v, hold_v;

  logic [3:0]  sel1, sel2, sel4;
  logic [0:0]  grant1;
  logic [1:0]  grant2;
  logic [3:0]  grant4;
  logic        sw1, sw2, sw4;
  logic [15:0] left1, left2, left4;

  logic [3:0]  o_sel   [3];
  logic [15:0] o_grant [3];
  logic        o_sw    [3];
  logic [15:0] o_left  [3];

  assign o_sel[0] = sel1;  assign o_grant[0] = {15'b0, grant1};
  assign o_sel[1] = sel2;  assign o_grant[1] = {14'b0, grant2};
  assign o_sel[2] = sel4;  assign o_grant[2] = {12'b0, grant4};
  assign o_sw[0] = sw1;    assign o_left[0] = left1;
  assign o_sw[1] = sw2;    assign o_left[1] = left2;
  assign o_sw[2] = sw4;    assign o_left[2] = left4;

  hart_timeslice_scheduler #(.N_HARTS(1), .QUANTUM(Q), .QW(16), .SELW(4)) u1 (
    .CLK(CLK), .RST_X(RST_X), .w_req(req_v[0][0:0]), .w_urgent(urg_v[0][0:0]),
    .w_safe(safe_v), .w_hold(hold_v), .w_sel(sel1), .w_grant(grant1),
    .w_switching(sw1), .w_quantum_left(left1));
  hart_timeslice_scheduler #(.N_HARTS(2), .QUANTUM(Q), .QW(16), .SELW(4)) u2 (
    .CLK(CLK), .RST_X(RST_X), .w_req(req_v[1][1:0]), .w_urgent(urg_v[1][1:0]),
    .w_safe(safe_v), .w_hold(hold_v), .w_sel(sel2), .w_grant(grant2),
    .w_switching(sw2), .w_quantum_left(left2));
  hart_timeslice_scheduler #(.N_HARTS(4), .QUANTUM(Q), .QW(16), .SELW(4)) u4 (
    .CLK(CLK), .RST_X(RST_X), .w_req(req_v[2][3:0]), .w_urgent(urg_v[2][3:0]),
    .w_safe(safe_v), .w_hold(hold_v), .w_sel(sel4), .w_grant(grant4),
    .w_switching(sw4), .w_quantum_left(left4));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: owner, remaining slice, phase (0 owning, 1 draining, 2 handing over).
  int nh [3] = '{1, 2, 4};
  int m_owner [3];
  int m_left  [3];
  int m_phase [3];
  int m_tgt   [3];

  function automatic int pick(input int n, input int owner, input logic [15:0] req,
                              input logic [15:0] urg, output int who);
    int h;
    who = owner;
    for (int d = 1; d < n; d++) begin
      h = (owner + d) % n;
      if (req[h] && urg[h]) begin who = h; return 2; end
    end
    for (int d = 1; d < n; d++) begin
      h = (owner + d) % n;
      if (req[h]) begin who = h; return 1; end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = 0; m_left[k] = Q; m_phase[k] = 0; m_tgt[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int kind, who;
    bit trig;
    kind = pick(nh[k], m_owner[k], req_v[k], urg_v[k], who);
    case (m_phase[k])
      0: begin
        trig = (kind > 0) && (m_left[k] == 0 || !req_v[k][m_owner[k]] ||
               (kind == 2 && !urg_v[k][m_owner[k]]));
        if (trig) begin
          m_phase[k] = 1;
          if (m_left[k] > 0) m_left[k]--;
        end else if (m_left[k] == 0) m_left[k] = Q;
        else m_left[k]--;
      end
      1: begin
        if (kind == 0) begin m_phase[k] = 0; m_left[k] = Q; end
        else if (safe_v && !hold_v) begin m_phase[k] = 2; m_tgt[k] = who; end
      end
      default: begin
        m_owner[k] = m_tgt[k]; m_left[k] = Q; m_phase[k] = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin req_v[k] = 16'hffff; urg_v[k] = 16'h0; end
    safe_v = 1'b1; hold_v = 1'b0;
    @(posedge CLK); #1;
    RST_X = 1'b0;
    model_reset();
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    RST_X = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (o_sel[k] !== 4'd0) begin
        n_bad++; $display("FAIL reset_sel[%0d]: got %0d want 0", k, o_sel[k]);
      end
      n_vec++;
      if (o_grant[k] !== 16'h1) begin
        n_bad++; $display("FAIL reset_grant[%0d]: got %h want 1", k, o_grant[k]);
      end
      n_vec++;
      if (o_sw[k] !== 1'b0 || o_left[k] !== 16'(Q)) begin
        n_bad++; $display("FAIL reset_sw_left[%0d]: got %b/%0d want 0/%0d", k, o_sw[k],
                          o_left[k], Q);
      end
    end
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  task automatic test_quantum();
    int cnt = 0;
    do_reset();
    while (o_grant[1] === 16'h1 && cnt < 40) begin
      n_vec++;
      if (o_left[1] !== 16'(m_left[1])) begin
        n_bad++; $display("FAIL quantum_left: got %0d want %0d", o_left[1], m_left[1]);
      end
      cnt++;
      tick();
    end
    // Counter values 8..0 while owning, then one draining cycle.
    n_vec++;
    if (cnt != Q + 2 || o_grant[1] !== 16'h0) begin
      n_bad++; $display("FAIL quantum_owned_cycles: got %0d/%h want %0d/0", cnt, o_grant[1], Q + 2);
    end
    tick();
    n_vec++;
    if (o_grant[1] !== 16'h2 || o_sel[1] !== 4'd1 || o_left[1] !== 16'(Q)) begin
      n_bad++; $display("FAIL quantum_handover: got grant %h sel %0d left %0d want 2/1/%0d",
                        o_grant[1], o_sel[1], o_left[1], Q);
    end
  endtask

  task automatic test_owner_idle();
    do_reset();
    repeat (3) tick();
    req_v[1] = 16'h2;
    tick();
    n_vec++;
    if (o_sw[1] !== 1'b1 || o_grant[1] !== 16'h1) begin
      n_bad++; $display("FAIL idle_drain: got sw %b grant %h want 1/1", o_sw[1], o_grant[1]);
    end
    tick();
    n_vec++;
    if (o_grant[1] !== 16'h0) begin
      n_bad++; $display("FAIL idle_switch: got grant %h want 0", o_grant[1]);
    end
    tick();
    n_vec++;
    if (o_sel[1] !== 4'd1 || o_grant[1] !== 16'h2 || o_left[1] !== 16'(Q)) begin
      n_bad++; $display("FAIL idle_newowner: got sel %0d grant %h left %0d want 1/2/%0d",
                        o_sel[1], o_grant[1], o_left[1], Q);
    end
  endtask

  task automatic test_preempt();
    int cnt = 0;
    do_reset();
    urg_v[2] = 16'h8;
    repeat (3) tick();
    n_vec++;
    if (o_sel[2] !== 4'd3 || o_grant[2] !== 16'h8) begin
      n_bad++; $display("FAIL preempt_target: got sel %0d grant %h want 3/8", o_sel[2], o_grant[2]);
    end
    do_reset();
    urg_v[2] = 16'h9;
    repeat (3) tick();
    n_vec++;
    if (o_sw[2] !== 1'b0 || o_sel[2] !== 4'd0) begin
      n_bad++; $display("FAIL preempt_owner_urgent: got sw %b sel %0d want 0/0", o_sw[2], o_sel[2]);
    end
    while (o_grant[2] !== 16'h0 && cnt < 40) begin cnt++; tick(); end
    tick();
    n_vec++;
    if (cnt >= 40 || o_sel[2] !== 4'd3) begin
      n_bad++; $display("FAIL preempt_at_expiry: got sel %0d after %0d cycles want 3", o_sel[2], cnt);
    end
  endtask

  task automatic test_hold_safe();
    int cnt = 0;
    do_reset();
    safe_v = 1'b0;
    while (o_sw[1] !== 1'b1 && cnt < 40) begin cnt++; tick(); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (o_sw[1] !== 1'b1 || o_grant[1] !== 16'h1 || o_left[1] !== 16'h0) begin
        n_bad++; $display("FAIL hold_unsafe_drain: got sw %b grant %h left %0d want 1/1/0",
                          o_sw[1], o_grant[1], o_left[1]);
      end
    end
    safe_v = 1'b1; hold_v = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (o_sw[1] !== 1'b1 || o_grant[1] !== 16'h1) begin
      n_bad++; $display("FAIL hold_blocks: got sw %b grant %h want 1/1", o_sw[1], o_grant[1]);
    end
    hold_v = 1'b0;
    tick();
    n_vec++;
    if (o_grant[1] !== 16'h0) begin
      n_bad++; $display("FAIL hold_release_switch: got grant %h want 0", o_grant[1]);
    end
    tick();
    n_vec++;
    if (o_grant[1] !== 16'h2 || o_sel[1] !== 4'd1) begin
      n_bad++; $display("FAIL hold_release_owner: got grant %h sel %0d want 2/1", o_grant[1], o_sel[1]);
    end
  endtask

  task automatic test_vanish();
    int cnt = 0;
    do_reset();
    safe_v = 1'b0;
    while (o_sw[1] !== 1'b1 && cnt < 40) begin cnt++; tick(); end
    req_v[1] = 16'h1;
    tick();
    n_vec++;
    if (o_sw[1] !== 1'b0 || o_sel[1] !== 4'd0 || o_left[1] !== 16'(Q)) begin
      n_bad++; $display("FAIL vanish_return: got sw %b sel %0d left %0d want 0/0/%0d",
                        o_sw[1], o_sel[1], o_left[1], Q);
    end
  endtask

  task automatic test_reset_mid_switch();
    do_reset();
    req_v[1] = 16'h2;
    repeat (2) tick();
    n_vec++;
    if (o_grant[1] !== 16'h0) begin
      n_bad++; $display("FAIL midswitch_precond: got grant %h want 0", o_grant[1]);
    end
    RST_X = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (o_sel[1] !== 4'd0 || o_grant[1] !== 16'h1 || o_sw[1] !== 1'b0) begin
      n_bad++; $display("FAIL midswitch_reset: got sel %0d grant %h sw %b want 0/1/0",
                        o_sel[1], o_grant[1], o_sw[1]);
    end
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (o_grant[0] !== 16'h1 || o_sw[0] !== 1'b0 || o_left[0] !== 16'(m_left[0])) begin
        n_bad++; $display("FAIL single_hart: got grant %h sw %b left %0d want 1/0/%0d",
                          o_grant[0], o_sw[0], o_left[0], m_left[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e_grant;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) begin
        req_v[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hffff;
        urg_v[k] = 16'($urandom) & 16'($urandom) & 16'($urandom);
      end
      safe_v = ($urandom_range(0, 3) != 0);
      hold_v = ($urandom_range(0, 5) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        e_grant = (m_phase[k] == 2) ? 16'h0 : 16'(1 << m_owner[k]);
        n_vec++;
        if (o_sel[k] !== 4'(m_owner[k]) || o_grant[k] !== e_grant ||
            o_sw[k] !== (m_phase[k] != 0) || o_left[k] !== 16'(m_left[k])) begin
          n_bad++;
          $display("FAIL random[%0d] cyc %0d: got sel %0d grant %h sw %b left %0d want %0d/%h/%b/%0d",
                   k, c, o_sel[k], o_grant[k], o_sw[k], o_left[k], m_owner[k], e_grant,
                   m_phase[k] != 0, m_left[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_quantum();
    test_owner_idle();
    test_preempt();
    test_hold_safe();
    test_vanish();
    test_reset_mid_switch();
    test_single();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
